// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access width codes, FSM states, request helpers.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

  // funct3 access width codes
  localparam logic [2:0] MA_BYTE  = 3'b000;
  localparam logic [2:0] MA_HALF  = 3'b001;
  localparam logic [2:0] MA_WORD  = 3'b010;
  localparam logic [2:0] MA_BYTEU = 3'b100;
  localparam logic [2:0] MA_HALFU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

  // Any memory access requested by the instruction in EX/MEM
  function automatic logic mem_req_f(input logic we, input logic re);
    return we | re;
  endfunction

  // Store wins when both request bits are set
  function automatic logic mem_write_f(input logic we);
    return we;
  endfunction

  // Bytes moved per access; code 11 is handled as a word
  function automatic logic [2:0] ma_nbytes(input logic [2:0] width);
    case (width[1:0])
      MA_BYTE[1:0]: return 3'd1;
      MA_HALF[1:0]: return 3'd2;
      MA_WORD[1:0]: return 3'd4;
      default:      return 3'd4;
    endcase
  endfunction

  // Zero-extension selected by the top funct3 bit (only matters for byte/half)
  function automatic logic ma_unsigned(input logic [2:0] width);
    return (width == MA_BYTEU) || (width == MA_HALFU);
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of the assembled load buffer to 32 bits.
// Latency: combinational.
// Backpressure: none.
module load_extend (
  input  logic [31:0] buffer,
  input  logic [2:0]  n_bytes,
  input  logic        is_unsigned,
  output logic [31:0] ext_data
);

  // Replicate the top valid bit (or zero) above the low n_bytes bytes
  always_comb begin
    ext_data = buffer;
    case (n_bytes)
      3'd1:    ext_data = {{24{~is_unsigned & buffer[7]}}, buffer[7:0]};
      3'd2:    ext_data = {{16{~is_unsigned & buffer[15]}}, buffer[15:0]};
      default: ext_data = buffer;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: ALU results pass straight to MEM/WB; loads/stores run byte-serial, little-endian.
// Latency: 0 cycles for non-memory ops; 1+N+1 cycles for an N-byte access with ack every cycle.
// Backpressure: stall_req holds upstream during access; mem_ack paces bytes; rdy=0 freezes all state.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              we_in,
  input  logic [4:0]        waddr_in,
  input  logic [31:0]       wdata_in,
  input  logic              ma_we_in,
  input  logic              ma_re_in,
  input  logic [2:0]        ma_width_in,
  input  logic [31:0]       ma_addr_in,
  input  logic [31:0]       ma_wdata_in,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [31:0]       wb_wdata,
  output logic              stall_req
);

  mem_state_t  state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] buffer, buffer_nxt;

  logic        mem_op;
  logic        is_store;
  logic [2:0]  n_bytes;
  logic        last_byte;
  logic [31:0] byte_addr;
  logic [31:0] load_word;

  assign mem_op    = mem_req_f(ma_we_in, ma_re_in);
  assign is_store  = mem_write_f(ma_we_in);
  assign n_bytes   = ma_nbytes(ma_width_in);
  assign last_byte = ({1'b0, cnt} == (n_bytes - 3'd1));
  // 32-bit wrap of base+offset; the port sees only the low ADDR_W bits
  assign byte_addr = ma_addr_in + {30'd0, cnt};

  load_extend u_load_extend (
    .buffer      (buffer),
    .n_bytes     (n_bytes),
    .is_unsigned (ma_unsigned(ma_width_in)),
    .ext_data    (load_word)
  );

  // State, byte counter and load buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MEM_IDLE;
      cnt    <= 2'd0;
      buffer <= 32'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      buffer <= buffer_nxt;
    end
  end

  // Next-state: advance only when rdy, one byte per accepted ack
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    buffer_nxt = buffer;
    if (rdy) begin
      case (state)
        MEM_IDLE: begin
          if (mem_op) begin
            state_nxt = MEM_ACCESS;
            cnt_nxt   = 2'd0;
          end
        end
        MEM_ACCESS: begin
          if (mem_ack) begin
            if (!is_store) buffer_nxt[{cnt, 3'b000} +: 8] = mem_rdata;
            if (last_byte) state_nxt = MEM_DONE;
            else           cnt_nxt   = cnt + 2'd1;
          end
        end
        MEM_DONE: state_nxt = MEM_IDLE;
        default:  state_nxt = MEM_IDLE;
      endcase
    end
  end

  // Outputs: forced low in reset so an aborted access drops mem_req at once
  always_comb begin
    mem_req   = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    wb_we     = 1'b0;
    wb_waddr  = 5'd0;
    wb_wdata  = 32'd0;
    stall_req = 1'b0;
    if (rst) begin
      wb_waddr = waddr_in;
      wb_wdata = wdata_in;
      case (state)
        MEM_IDLE: begin
          stall_req = mem_op;
          wb_we     = we_in & ~mem_op;
        end
        MEM_ACCESS: begin
          stall_req = 1'b1;
          mem_req   = rdy;
          mem_rw    = is_store;
          mem_addr  = byte_addr[ADDR_W-1:0];
          mem_wdata = ma_wdata_in[{cnt, 3'b000} +: 8];
        end
        MEM_DONE: begin
          wb_we    = we_in;
          wb_wdata = is_store ? wdata_in : load_word;
        end
        default: ;
      endcase
    end
  end

endmodule
